// File: rtl/ah_pl2ddr_pkg.sv
// Shared types and elaboration helpers for the PL-to-DDR sample packer.
// A FIFO entry is laid out as {tlast, tdata}, so tlast sits at bit OUT_WIDTH.
package ah_pl2ddr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    function automatic int pack_ratio(input int out_w, input int data_w);
        return out_w / data_w;
    endfunction

    function automatic int entry_width(input int out_w);
        return out_w + 1;
    endfunction

endpackage

// File: rtl/ah_pl2ddr_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible whenever empty_o=0.
// A push on a full FIFO only lands when a pop happens in the same cycle.
module ah_pl2ddr_sync_fifo
    import ah_pl2ddr_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = clog2_f(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             do_push, do_pop;

    assign empty_o    = (wr_q == rd_q);
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/ah_pl2ddr_sample_packer.sv
// Packs DATA_WIDTH samples LSB-lane-first into OUT_WIDTH words for a programmed
// transfer length and streams them out through a FWFT FIFO with tlast on the final word.
module ah_pl2ddr_sample_packer
    import ah_pl2ddr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [31:0]           sample_count,
    input  logic                  enable_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [OUT_WIDTH-1:0]  m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [31:0]           words_out
);

    localparam int PACK  = pack_ratio(OUT_WIDTH, DATA_WIDTH);
    localparam int IDX_W = (PACK > 1) ? clog2_f(PACK) : 1;
    localparam int EW    = entry_width(OUT_WIDTH);

    state_e                 state_q, state_d;
    logic [31:0]            remaining_q, remaining_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [OUT_WIDTH-1:0]   pack_q, pack_d;
    logic                   push_q, push_d;
    logic [OUT_WIDTH-1:0]   push_data_q, push_data_d;
    logic                   push_last_q, push_last_d;
    logic                   overflow_q, overflow_d;
    logic [31:0]            words_out_q, words_out_d;

    logic [OUT_WIDTH-1:0]   word_merged;
    logic [EW-1:0]          fifo_head;
    logic                   fifo_full, fifo_empty, fifo_pop;
    logic                   last_sample;

    // Lanes above idx stay zero because pack_q is cleared after each word, which
    // gives the zero padding of a short final word for free.
    generate
        for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
            assign word_merged[gi*DATA_WIDTH +: DATA_WIDTH] =
                (idx_q == IDX_W'(gi)) ? data_in : pack_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign last_sample = (remaining_q == 32'd1);
    assign fifo_pop    = m_tvalid && m_tready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        pack_d      = pack_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        push_last_d = push_last_q;
        overflow_d  = overflow_q;
        words_out_d = words_out_q + 32'(fifo_pop);

        if (push_q && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && (sample_count != 32'd0)) begin
                    remaining_d = sample_count;
                    idx_d       = '0;
                    pack_d      = '0;
                    overflow_d  = 1'b0;
                    words_out_d = 32'd0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (enable_in) begin
                    remaining_d = remaining_q - 32'd1;
                    if ((idx_q == IDX_W'(PACK - 1)) || last_sample) begin
                        push_d      = 1'b1;
                        push_data_d = word_merged;
                        push_last_d = last_sample;
                        pack_d      = '0;
                        idx_d       = '0;
                        if (last_sample) state_d = ST_FLUSH;
                    end else begin
                        pack_d = word_merged;
                        idx_d  = idx_q + 1'b1;
                    end
                end
            end
            // With no push pending, an empty FIFO means the tlast word has either
            // handshaken or been dropped.
            ST_FLUSH: begin
                if (!push_q && fifo_empty) state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            idx_q       <= '0;
            pack_q      <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            push_last_q <= 1'b0;
            overflow_q  <= 1'b0;
            words_out_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            pack_q      <= pack_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            push_last_q <= push_last_d;
            overflow_q  <= overflow_d;
            words_out_q <= words_out_d;
        end
    end

    ah_pl2ddr_sync_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_i     (push_q),
        .push_data_i({push_last_q, push_data_q}),
        .pop_i      (fifo_pop),
        .pop_data_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign m_tvalid  = !fifo_empty;
    assign m_tdata   = fifo_empty ? '0 : fifo_head[OUT_WIDTH-1:0];
    assign m_tlast   = !fifo_empty && fifo_head[OUT_WIDTH];
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign overflow  = overflow_q;
    assign words_out = words_out_q;

endmodule
